// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory bus port between instruction fetch and load/store.
// Optional response watchdog and ERR_TIMEOUT port enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYC     = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  output logic        INST_STALL,
  input  logic        DATA_RDEN,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_ADDR,
  input  logic [31:0] DATA_WDATA,
  input  logic [3:0]  DATA_STRB,
  output logic        DATA_DONE,
  output logic [31:0] DATA_RDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_STRB,
  input  logic        MEM_READY,
  input  logic        MEM_RVALID,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic        ERR_TIMEOUT,
`endif
  input  logic [31:0] MEM_RDATA
);

  localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state;
  logic          owner_fetch;
  logic          discard;
  logic [SW-1:0] streak;

  logic data_req, fetch_req, fetch_turn;
  logic grant_data, grant_fetch;
  logic resp, timeout, finish, fin_data, fin_fetch;

  // Data wins by default; fetch takes one turn after a full data streak.
  assign data_req    = DATA_RDEN || DATA_WREN;
  assign fetch_req   = INST_RDEN && !FLUSH;
  assign fetch_turn  = fetch_req && (!data_req || (streak == STREAK_MAX));
  assign grant_data  = (state == S_IDLE) && data_req && !fetch_turn;
  assign grant_fetch = (state == S_IDLE) && fetch_turn;

  assign resp      = (state == S_WAIT) && MEM_RVALID;
  assign finish    = resp || timeout;
  assign fin_data  = finish && !owner_fetch;
  assign fin_fetch = finish && owner_fetch && !discard && !FLUSH;

  // Completion is signalled in the response cycle so requesters can move on next cycle.
  assign DATA_DONE   = fin_data;
  assign DATA_RDATA  = !fin_data ? 32'h0 : (resp ? MEM_RDATA : 32'h0);
  assign INST_RVALID = fin_fetch;
  assign INST_RDATA  = !fin_fetch ? 32'h0 : (resp ? MEM_RDATA : 32'h0000_0013);
  assign INST_STALL  = INST_RDEN && !INST_RVALID;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] tcnt;

  assign timeout = (state != S_IDLE) && (tcnt == TIMEOUT_LIM);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt        <= 16'h0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      if (grant_data || grant_fetch)
        tcnt <= 16'h0;
      else if ((state != S_IDLE) && (tcnt != 16'hffff))
        tcnt <= tcnt + 16'h1;
      if (timeout)
        ERR_TIMEOUT <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      owner_fetch <= 1'b0;
      discard     <= 1'b0;
      streak      <= '0;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= 32'h0;
      MEM_WDATA   <= 32'h0;
      MEM_STRB    <= 4'h0;
    end else begin
      if (!INST_RDEN || grant_fetch)
        streak <= '0;
      else if (grant_data && (streak != STREAK_MAX))
        streak <= streak + SW'(1);

      case (state)
        S_IDLE: begin
          if (grant_data) begin
            state       <= S_ISSUE;
            owner_fetch <= 1'b0;
            discard     <= 1'b0;
            MEM_REQ     <= 1'b1;
            MEM_WE      <= DATA_WREN;
            MEM_ADDR    <= DATA_ADDR;
            MEM_WDATA   <= DATA_WREN ? DATA_WDATA : 32'h0;
            MEM_STRB    <= DATA_WREN ? DATA_STRB : 4'hf;
          end else if (grant_fetch) begin
            state       <= S_ISSUE;
            owner_fetch <= 1'b1;
            discard     <= 1'b0;
            MEM_REQ     <= 1'b1;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= INST_RIADDR;
            MEM_WDATA   <= 32'h0;
            MEM_STRB    <= 4'hf;
          end
        end
        S_ISSUE: begin
          // A flushed fetch still completes on the bus; only its result is dropped.
          if (FLUSH && owner_fetch)
            discard <= 1'b1;
          if (MEM_READY) begin
            MEM_REQ <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (FLUSH && owner_fetch)
            discard <= 1'b1;
          if (MEM_RVALID) begin
            state   <= S_IDLE;
            discard <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (timeout) begin
        state   <= S_IDLE;
        MEM_REQ <= 1'b0;
        discard <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus hand sequences for
// bus back-pressure, async reset and the fetch anti-starvation streak.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FLUSH, INST_RDEN, DATA_RDEN, DATA_WREN, MEM_READY, MEM_RVALID;
  logic [31:0] INST_RIADDR, DATA_ADDR, DATA_WDATA, MEM_RDATA;
  logic [3:0]  DATA_STRB;
  logic        INST_RVALID, INST_STALL, DATA_DONE, MEM_REQ, MEM_WE;
  logic [31:0] INST_RDATA, DATA_RDATA, MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_STRB;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        ERR_TIMEOUT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic fl, ird; logic [31:0] ia;
    logic drd, dwr; logic [31:0] da, dwd; logic [3:0] ds;
    logic rdy, rv; logic [31:0] rd;
    logic ereq, ewe; logic [31:0] eaddr, ewdata; logic [3:0] estrb;
    logic eiv; logic [31:0] eid; logic estall, edone; logic [31:0] edd;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT_CYC(256)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_RVALID(INST_RVALID),
    .INST_RDATA(INST_RDATA), .INST_STALL(INST_STALL),
    .DATA_RDEN(DATA_RDEN), .DATA_WREN(DATA_WREN), .DATA_ADDR(DATA_ADDR),
    .DATA_WDATA(DATA_WDATA), .DATA_STRB(DATA_STRB), .DATA_DONE(DATA_DONE),
    .DATA_RDATA(DATA_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_STRB(MEM_STRB), .MEM_READY(MEM_READY), .MEM_RVALID(MEM_RVALID),
`ifdef MEM_ARB_TIMEOUT_EN
    .ERR_TIMEOUT(ERR_TIMEOUT),
`endif
    .MEM_RDATA(MEM_RDATA)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    FLUSH = 1'b0; INST_RDEN = 1'b0; INST_RIADDR = 32'h0;
    DATA_RDEN = 1'b0; DATA_WREN = 1'b0; DATA_ADDR = 32'h0; DATA_WDATA = 32'h0; DATA_STRB = 4'h0;
    MEM_READY = 1'b1; MEM_RVALID = 1'b0; MEM_RDATA = 32'h0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge CLK); #1;
    FLUSH = v.fl; INST_RDEN = v.ird; INST_RIADDR = v.ia;
    DATA_RDEN = v.drd; DATA_WREN = v.dwr; DATA_ADDR = v.da; DATA_WDATA = v.dwd; DATA_STRB = v.ds;
    MEM_READY = v.rdy; MEM_RVALID = v.rv; MEM_RDATA = v.rd;
    @(negedge CLK);
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("vec%0d_mem_req", i), 32'(MEM_REQ), 32'(v.ereq));
    checkOutput($sformatf("vec%0d_inst_stall", i), 32'(INST_STALL), 32'(v.estall));
    checkOutput($sformatf("vec%0d_inst_rvalid", i), 32'(INST_RVALID), 32'(v.eiv));
    checkOutput($sformatf("vec%0d_data_done", i), 32'(DATA_DONE), 32'(v.edone));
    if (v.ereq) begin
      checkOutput($sformatf("vec%0d_mem_addr", i), MEM_ADDR, v.eaddr);
      checkOutput($sformatf("vec%0d_mem_we", i), 32'(MEM_WE), 32'(v.ewe));
      checkOutput($sformatf("vec%0d_mem_strb", i), 32'(MEM_STRB), 32'(v.estrb));
      if (v.ewe) checkOutput($sformatf("vec%0d_mem_wdata", i), MEM_WDATA, v.ewdata);
    end
    if (v.eiv)   checkOutput($sformatf("vec%0d_inst_rdata", i), INST_RDATA, v.eid);
    if (v.edone) checkOutput($sformatf("vec%0d_data_rdata", i), DATA_RDATA, v.edd);
  endtask

  // Fields: fl,ird,ia, drd,dwr,da,dwd,ds, rdy,rv,rd, ereq,ewe,eaddr,ewdata,estrb, eiv,eid,estall,edone,edd
  task automatic fillTable();
    // fetch only, 2-cycle bus latency
    vecs.push_back('{1'b0,1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,32'h100,32'h0,4'hf, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b1,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'hDEADBEEF,1'b0,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,1'b0,32'h0});
    // stray response while idle is ignored
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b1,32'h55, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,1'b0,32'h0});
    // store and fetch together: store first, fetch after DATA_DONE
    vecs.push_back('{1'b0,1'b1,32'h300, 1'b0,1'b1,32'h2000,32'h12345678,4'h3, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h300, 1'b0,1'b1,32'h2000,32'h12345678,4'h3, 1'b1,1'b0,32'h0, 1'b1,1'b1,32'h2000,32'h12345678,4'h3, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h300, 1'b0,1'b1,32'h2000,32'h12345678,4'h3, 1'b1,1'b1,32'h600D600D, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b1,32'h600D600D});
    vecs.push_back('{1'b0,1'b1,32'h300, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h300, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,32'h300,32'h0,4'hf, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h300, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b1,32'hCAFEF00D, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'hCAFEF00D,1'b0,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,1'b0,32'h0});
    // load and store both set: treated as a write
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b1,1'b1,32'h2400,32'hAABBCCDD,4'hc, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b1,1'b1,32'h2400,32'hAABBCCDD,4'hc, 1'b1,1'b0,32'h0, 1'b1,1'b1,32'h2400,32'hAABBCCDD,4'hc, 1'b0,32'h0,1'b0,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b1,1'b1,32'h2400,32'hAABBCCDD,4'hc, 1'b1,1'b1,32'h0BADF00D, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,1'b1,32'h0BADF00D});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,1'b0,32'h0});
    // flush in idle blocks the grant; flush during WAIT drops the response; refetch at 0x400
    vecs.push_back('{1'b1,1'b1,32'h600, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h600, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h600, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,32'h600,32'h0,4'hf, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b1,1'b1,32'h400, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h400, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b1,32'h11111111, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h400, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h400, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b1,1'b0,32'h400,32'h0,4'hf, 1'b0,32'h0,1'b1,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b1,32'h400, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b1,32'h22222222, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h22222222,1'b0,1'b0,32'h0});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,1'b0,1'b0,32'h0});
  endtask

  task automatic runReadyLow();
    int accepts = 0;
    @(posedge CLK); #1;
    DATA_RDEN = 1'b1; DATA_ADDR = 32'h700; MEM_READY = 1'b0;
    @(negedge CLK);
    checkOutput("rdy_req_before_grant", 32'(MEM_REQ), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput($sformatf("rdy_hold%0d_req", k), 32'(MEM_REQ), 32'd1);
      checkOutput($sformatf("rdy_hold%0d_addr", k), MEM_ADDR, 32'h700);
      if (MEM_REQ && MEM_READY) accepts++;
    end
    @(posedge CLK); #1;
    MEM_READY = 1'b1;
    @(negedge CLK);
    checkOutput("rdy_accept_strb", 32'(MEM_STRB), 32'hf);
    if (MEM_REQ && MEM_READY) accepts++;
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("rdy_req_dropped", 32'(MEM_REQ), 32'd0);
    if (MEM_REQ && MEM_READY) accepts++;
    @(posedge CLK); #1;
    MEM_RVALID = 1'b1; MEM_RDATA = 32'h77777777;
    @(negedge CLK);
    checkOutput("rdy_done", 32'(DATA_DONE), 32'd1);
    checkOutput("rdy_rdata", DATA_RDATA, 32'h77777777);
    @(posedge CLK); #1;
    DATA_RDEN = 1'b0; MEM_RVALID = 1'b0;
    @(negedge CLK);
    if (MEM_REQ && MEM_READY) accepts++;
    checkOutput("rdy_single_transfer", 32'(accepts), 32'd1);
  endtask

  task automatic runAsyncReset();
    @(posedge CLK); #1;
    INST_RDEN = 1'b1; INST_RIADDR = 32'h800; MEM_READY = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("arst_req_before", 32'(MEM_REQ), 32'd1);
    #2 RST = 1'b1;
    #1;
    checkOutput("arst_req_cleared", 32'(MEM_REQ), 32'd0);
    checkOutput("arst_addr_cleared", MEM_ADDR, 32'h0);
    checkOutput("arst_stall_held", 32'(INST_STALL), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0; MEM_READY = 1'b1;
    @(negedge CLK);
    checkOutput("arst_idle_after", 32'(MEM_REQ), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("arst_regrant_req", 32'(MEM_REQ), 32'd1);
    checkOutput("arst_regrant_addr", MEM_ADDR, 32'h800);
    @(posedge CLK); #1;
    MEM_RVALID = 1'b1; MEM_RDATA = 32'h88888888;
    @(negedge CLK);
    checkOutput("arst_fetch_valid", 32'(INST_RVALID), 32'd1);
    checkOutput("arst_fetch_data", INST_RDATA, 32'h88888888);
    @(posedge CLK); #1;
    INST_RDEN = 1'b0; MEM_RVALID = 1'b0;
  endtask

  // Bus answers one cycle after each accept; the load master advances on DATA_DONE.
  task automatic runStreak();
    logic [31:0] d_addr, acc_addr;
    logic        accept_now;
    int          order[$];
    int          expected[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    d_addr = 32'h3000; acc_addr = 32'h0; accept_now = 1'b0;
    @(posedge CLK); #1;
    DATA_RDEN = 1'b1; DATA_ADDR = d_addr; INST_RDEN = 1'b1; INST_RIADDR = 32'h500;
    MEM_READY = 1'b1; MEM_RVALID = 1'b0;
    for (int cyc = 0; cyc < 300 && order.size() < 10; cyc++) begin
      @(negedge CLK);
      accept_now = MEM_REQ && MEM_READY;
      if (accept_now) begin
        order.push_back((MEM_ADDR == 32'h500) ? 1 : 0);
        acc_addr = MEM_ADDR;
      end
      if (DATA_DONE) begin
        checkOutput("streak_load_data", DATA_RDATA, d_addr ^ 32'hA5A50000);
        d_addr = d_addr + 32'd4;
      end
      if (INST_RVALID) checkOutput("streak_fetch_data", INST_RDATA, 32'h500 ^ 32'hA5A50000);
      @(posedge CLK); #1;
      MEM_RVALID = accept_now; MEM_RDATA = acc_addr ^ 32'hA5A50000; DATA_ADDR = d_addr;
    end
    checkOutput("streak_grant_count", 32'(order.size()), 32'd10);
    for (int i = 0; i < order.size() && i < 10; i++)
      checkOutput($sformatf("streak_grant%0d_is_fetch", i), 32'(order[i]), 32'(expected[i]));
  endtask

  initial begin
    idleInputs();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("rst_mem_req", 32'(MEM_REQ), 32'd0);
    checkOutput("rst_mem_we", 32'(MEM_WE), 32'd0);
    checkOutput("rst_mem_addr", MEM_ADDR, 32'h0);
    checkOutput("rst_mem_wdata", MEM_WDATA, 32'h0);
    checkOutput("rst_mem_strb", 32'(MEM_STRB), 32'h0);
    checkOutput("rst_inst_rvalid", 32'(INST_RVALID), 32'd0);
    checkOutput("rst_inst_rdata", INST_RDATA, 32'h0);
    checkOutput("rst_inst_stall", 32'(INST_STALL), 32'd0);
    checkOutput("rst_data_done", 32'(DATA_DONE), 32'd0);
    checkOutput("rst_data_rdata", DATA_RDATA, 32'h0);
    RST = 1'b0;

    fillTable();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    runReadyLow();
    runAsyncReset();
    runStreak();

    @(posedge CLK); #1;
    idleInputs();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
